// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//
// Plays a 16-bit blink pattern on a light. Each bit is shown for one step.
// A step is any change of the slow TICK_IN level, and STEP_DIV steps are
// grouped into one pattern advance. Steps 0..LENGTH are played, either once
// or looping.
//
// Ports
//   CLOCK_50   : system clock; all flops use its rising edge
//   RESET_N    : asynchronous active-low reset
//   TICK_IN    : slow toggling level; both edges count as a step
//   START      : one-cycle request to begin playing (ignored while running)
//   STOP       : one-cycle request to abort; wins over START and over an advance
//   PATTERN    : blink pattern, bit i = light state for step i
//   LENGTH     : last step index to play
//   REPEAT     : 1 = loop the pattern, 0 = play once
//   ON_LIGHT   : registered light drive
//   OFF_LIGHT  : inverse of ON_LIGHT
//   BUSY       : high while the pattern is playing
//   DONE       : one-cycle pulse at the end of each pattern pass
module led_pattern_sequencer #(
   parameter int unsigned STEP_DIV = 1
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic        TICK_IN,
   input  logic        START,
   input  logic        STOP,
   input  logic [15:0] PATTERN,
   input  logic [3:0]  LENGTH,
   input  logic        REPEAT,
   output logic        ON_LIGHT,
   output logic        OFF_LIGHT,
   output logic        BUSY,
   output logic        DONE
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

   state_t      state_q, state_d;
   logic        tick_sync1, tick_sync2, tick_prev;
   logic [1:0]  arm_cnt;
   logic        step;
   logic        advance;
   logic [7:0]  div_q, div_d;
   logic [3:0]  index_q, index_d;
   logic [15:0] pat_q, pat_d;
   logic [3:0]  len_q, len_d;
   logic        on_q, on_d;
   logic        done_q, done_d;

   // Two-flop synchronizer plus a history register for edge detection.
   // The step pulse itself is registered, so a TICK_IN change captured at
   // edge k shows up as step in the cycle after edge k+2. arm_cnt keeps
   // step quiet for the first three cycles after reset release, so a
   // TICK_IN that is already high at release is not mistaken for an edge.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         tick_sync1 <= 1'b0;
         tick_sync2 <= 1'b0;
         tick_prev  <= 1'b0;
         arm_cnt    <= 2'd0;
         step       <= 1'b0;
      end else begin
         tick_sync1 <= TICK_IN;
         tick_sync2 <= tick_sync1;
         tick_prev  <= tick_sync2;
         if (arm_cnt != 2'd3) begin
            arm_cnt <= arm_cnt + 2'd1;
         end
         step <= (tick_sync2 ^ tick_prev) & (arm_cnt == 2'd3);
      end
   end

   // State and datapath registers.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         div_q   <= 8'd0;
         index_q <= 4'd0;
         pat_q   <= 16'd0;
         len_q   <= 4'd0;
         on_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         index_q <= index_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         on_q    <= on_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic. The light register follows the current index, so an
   // index change becomes visible one cycle later. The exceptions are START,
   // which loads PATTERN[0] directly so the first step shows up at once, and
   // any return to IDLE, which blanks the light on the same edge. STOP is
   // checked before advance so an abort never produces a DONE pulse.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      index_d = index_q;
      pat_d   = pat_q;
      len_d   = len_q;
      on_d    = 1'b0;
      done_d  = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE: begin
            div_d   = 8'd0;
            index_d = 4'd0;
            if (START && !STOP) begin
               state_d = RUN;
               pat_d   = PATTERN;
               len_d   = LENGTH;
               on_d    = PATTERN[0];
            end
         end
         RUN: begin
            on_d = pat_q[index_q];
            if (step) begin
               if (div_q == DIV_LAST) begin
                  advance = 1'b1;
                  div_d   = 8'd0;
               end else begin
                  div_d = div_q + 8'd1;
               end
            end
            if (STOP) begin
               state_d = IDLE;
               on_d    = 1'b0;
               div_d   = 8'd0;
               index_d = 4'd0;
            end else if (advance) begin
               if (index_q == len_q) begin
                  done_d  = 1'b1;
                  index_d = 4'd0;
                  if (!REPEAT) begin
                     state_d = IDLE;
                     on_d    = 1'b0;
                  end
               end else begin
                  index_d = index_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ON_LIGHT  = on_q;
   assign OFF_LIGHT = ~on_q;
   assign BUSY      = (state_q == RUN);
   assign DONE      = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//
// Drives two sequencers from the same stimulus: one with STEP_DIV=1 and one
// with STEP_DIV=3. A behavioural model predicts the outputs of both from the
// TICK_IN history and the control inputs, and the outputs are compared with
// it on every falling clock edge. Directed scenarios add literal checks at
// known points.
module tb_led_pattern_sequencer;

   localparam int DIV_B = 3;

   logic        CLOCK_50;
   logic        RESET_N;
   logic        TICK_IN;
   logic        START;
   logic        STOP;
   logic [15:0] PATTERN;
   logic [3:0]  LENGTH;
   logic        REPEAT;

   logic on_a, off_a, busy_a, done_a;
   logic on_b, off_b, busy_b, done_b;

   int n_checks;
   int n_pass;
   int done_cnt_a;
   int done_cnt_b;
   int saved;

   led_pattern_sequencer #(.STEP_DIV(1)) dut_a (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .TICK_IN  (TICK_IN),
      .START    (START),
      .STOP     (STOP),
      .PATTERN  (PATTERN),
      .LENGTH   (LENGTH),
      .REPEAT   (REPEAT),
      .ON_LIGHT (on_a),
      .OFF_LIGHT(off_a),
      .BUSY     (busy_a),
      .DONE     (done_a)
   );

   led_pattern_sequencer #(.STEP_DIV(DIV_B)) dut_b (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .TICK_IN  (TICK_IN),
      .START    (START),
      .STOP     (STOP),
      .PATTERN  (PATTERN),
      .LENGTH   (LENGTH),
      .REPEAT   (REPEAT),
      .ON_LIGHT (on_b),
      .OFF_LIGHT(off_b),
      .BUSY     (busy_b),
      .DONE     (done_b)
   );

   // 50 MHz clock.
   initial begin
      CLOCK_50 = 1'b0;
      forever #10 CLOCK_50 = ~CLOCK_50;
   end

   // Behavioural model. A TICK_IN change sampled at edge e is acted on by
   // the pattern logic at edge e+3; changes whose action edge falls in the
   // first four edges after release are discarded. Every STEP_DIV steps make
   // one advance. The light shows the bit of the index held before the edge,
   // except right after START (bit 0) and whenever playback ends (dark).
   bit        hist [0:16383];
   int        edge_n;
   logic      m_step;
   logic      m_adv;
   logic      m_busy [2];
   logic      m_on   [2];
   logic      m_done [2];
   logic [15:0] m_pat [2];
   int        m_len  [2];
   int        m_idx  [2];
   int        m_cnt  [2];
   int        m_div  [2];

   always @(posedge CLOCK_50 or negedge RESET_N) begin
      m_div[0] = 1;
      m_div[1] = DIV_B;
      if (!RESET_N) begin
         edge_n  = 0;
         hist[0] = 1'b0;
         for (int m = 0; m < 2; m++) begin
            m_busy[m] = 1'b0;
            m_on[m]   = 1'b0;
            m_done[m] = 1'b0;
            m_pat[m]  = 16'd0;
            m_len[m]  = 0;
            m_idx[m]  = 0;
            m_cnt[m]  = 0;
         end
      end else begin
         if (edge_n < 16383) begin
            edge_n = edge_n + 1;
         end
         hist[edge_n] = TICK_IN;
         m_step = (edge_n >= 5) && (hist[edge_n-3] != hist[edge_n-4]);
         for (int m = 0; m < 2; m++) begin
            m_done[m] = 1'b0;
            if (!m_busy[m]) begin
               m_on[m] = 1'b0;
               if (START && !STOP) begin
                  m_busy[m] = 1'b1;
                  m_pat[m]  = PATTERN;
                  m_len[m]  = int'(LENGTH);
                  m_idx[m]  = 0;
                  m_cnt[m]  = 0;
                  m_on[m]   = PATTERN[0];
               end
            end else begin
               m_adv   = 1'b0;
               m_on[m] = m_pat[m][m_idx[m]];
               if (m_step) begin
                  m_cnt[m] = m_cnt[m] + 1;
                  if (m_cnt[m] == m_div[m]) begin
                     m_cnt[m] = 0;
                     m_adv    = 1'b1;
                  end
               end
               if (STOP) begin
                  m_busy[m] = 1'b0;
                  m_on[m]   = 1'b0;
               end else if (m_adv) begin
                  if (m_idx[m] == m_len[m]) begin
                     m_done[m] = 1'b1;
                     m_idx[m]  = 0;
                     if (!REPEAT) begin
                        m_busy[m] = 1'b0;
                        m_on[m]   = 1'b0;
                     end
                  end else begin
                     m_idx[m] = m_idx[m] + 1;
                  end
               end
            end
         end
      end
   end

   task automatic check_output(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_count(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus DONE pulse counting.
   always @(negedge CLOCK_50) begin
      check_output("cmp_on_a",   on_a,   m_on[0]);
      check_output("cmp_off_a",  off_a,  ~m_on[0]);
      check_output("cmp_busy_a", busy_a, m_busy[0]);
      check_output("cmp_done_a", done_a, m_done[0]);
      check_output("cmp_on_b",   on_b,   m_on[1]);
      check_output("cmp_off_b",  off_b,  ~m_on[1]);
      check_output("cmp_busy_b", busy_b, m_busy[1]);
      check_output("cmp_done_b", done_b, m_done[1]);
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
   end

   // Advance n rising edges and settle 2 ns past the last one.
   task automatic step_cycles(input int n);
      repeat (n) @(posedge CLOCK_50);
      #2;
   endtask

   task automatic apply_stimulus(input logic [15:0] pat, input logic [3:0] len, input logic rep);
      PATTERN = pat;
      LENGTH  = len;
      REPEAT  = rep;
      START   = 1'b1;
      step_cycles(1);
      START   = 1'b0;
   endtask

   task automatic pulse_stop();
      STOP = 1'b1;
      step_cycles(1);
      STOP = 1'b0;
      step_cycles(1);
   endtask

   // One TICK_IN change, then wait until its effect on the light is visible.
   task automatic toggle_tick();
      TICK_IN = ~TICK_IN;
      step_cycles(5);
   endtask

   initial begin
      logic [15:0] patv;
      n_checks   = 0;
      n_pass     = 0;
      done_cnt_a = 0;
      done_cnt_b = 0;
      RESET_N = 1'b0;
      TICK_IN = 1'b0;
      START   = 1'b0;
      STOP    = 1'b0;
      PATTERN = 16'd0;
      LENGTH  = 4'd0;
      REPEAT  = 1'b0;
      step_cycles(3);

      // Reset values.
      check_output("rst_on",   on_a,   1'b0);
      check_output("rst_off",  off_a,  1'b1);
      check_output("rst_busy", busy_a, 1'b0);
      check_output("rst_done", done_a, 1'b0);
      RESET_N = 1'b1;
      step_cycles(4);

      // Single pass of 0x0005 over steps 0..3: light 1,0,1,0 then IDLE.
      apply_stimulus(16'h0005, 4'd3, 1'b0);
      check_output("p1_on0",   on_a,   1'b1);
      check_output("p1_busy",  busy_a, 1'b1);
      toggle_tick();
      check_output("p1_on1", on_a, 1'b0);
      toggle_tick();
      check_output("p1_on2", on_a, 1'b1);
      toggle_tick();
      check_output("p1_on3", on_a, 1'b0);
      saved = done_cnt_a;
      toggle_tick();
      check_count("p1_done",   done_cnt_a, saved + 1);
      check_output("p1_idle",  busy_a, 1'b0);
      check_output("p1_dark",  on_a,   1'b0);
      pulse_stop();

      // Edge latency, rising then falling TICK_IN.
      apply_stimulus(16'h0002, 4'd5, 1'b0);
      check_output("lat_start", on_a, 1'b0);
      TICK_IN = ~TICK_IN;
      step_cycles(4);
      check_output("lat_rise_early", on_a, 1'b0);
      step_cycles(1);
      check_output("lat_rise_on", on_a, 1'b1);
      TICK_IN = ~TICK_IN;
      step_cycles(4);
      check_output("lat_fall_early", on_a, 1'b1);
      step_cycles(1);
      check_output("lat_fall_on", on_a, 1'b0);
      pulse_stop();

      // Divide-by-3 with repeat: light changes every third toggle.
      saved = done_cnt_b;
      apply_stimulus(16'h0001, 4'd1, 1'b1);
      for (int t = 1; t <= 12; t++) begin
         toggle_tick();
         check_output("div_on", on_b, ((t / 3) % 2 == 0) ? 1'b1 : 1'b0);
      end
      check_count("div_done",   done_cnt_b, saved + 2);
      check_output("div_busy",  busy_b, 1'b1);
      pulse_stop();

      // STOP coincident with the final advance: no DONE, back to IDLE.
      saved = done_cnt_a;
      apply_stimulus(16'h0001, 4'd0, 1'b0);
      TICK_IN = ~TICK_IN;
      step_cycles(3);
      STOP = 1'b1;
      step_cycles(1);
      STOP = 1'b0;
      step_cycles(3);
      check_output("abort_busy", busy_a, 1'b0);
      check_count("abort_done",  done_cnt_a, saved);

      // START and STOP together in IDLE: STOP wins.
      START = 1'b1;
      STOP  = 1'b1;
      step_cycles(1);
      START = 1'b0;
      STOP  = 1'b0;
      step_cycles(1);
      check_output("ss_busy_a", busy_a, 1'b0);
      check_output("ss_busy_b", busy_b, 1'b0);

      // LENGTH=0: a single step then DONE.
      saved = done_cnt_a;
      apply_stimulus(16'h0001, 4'd0, 1'b0);
      check_output("len0_on", on_a, 1'b1);
      toggle_tick();
      check_count("len0_done",  done_cnt_a, saved + 1);
      check_output("len0_busy", busy_a, 1'b0);
      pulse_stop();

      // LENGTH=15 with 0xA5C3, PATTERN changed after START must be ignored.
      patv = 16'hA5C3;
      saved = done_cnt_a;
      apply_stimulus(patv, 4'd15, 1'b0);
      PATTERN = 16'h0000;
      LENGTH  = 4'd2;
      check_output("full_bit0", on_a, patv[0]);
      for (int i = 1; i < 16; i++) begin
         toggle_tick();
         check_output("full_bit", on_a, patv[i]);
      end
      toggle_tick();
      check_count("full_done",  done_cnt_a, saved + 1);
      check_output("full_busy", busy_a, 1'b0);
      pulse_stop();

      // Reset asserted mid-run acts immediately.
      saved = done_cnt_a;
      apply_stimulus(16'h000F, 4'd3, 1'b1);
      step_cycles(2);
      check_output("mid_on", on_a, 1'b1);
      #5;
      RESET_N = 1'b0;
      #1;
      check_output("arst_on",   on_a,   1'b0);
      check_output("arst_off",  off_a,  1'b1);
      check_output("arst_busy", busy_a, 1'b0);
      check_output("arst_done", done_a, 1'b0);
      TICK_IN = 1'b1;
      step_cycles(3);

      // TICK_IN high through release must not produce a step.
      RESET_N = 1'b1;
      step_cycles(1);
      apply_stimulus(16'h0001, 4'd3, 1'b0);
      step_cycles(20);
      check_output("hold_on",   on_a,   1'b1);
      check_output("hold_busy", busy_a, 1'b1);
      check_count("hold_done",  done_cnt_a, saved);
      pulse_stop();
      step_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
